// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             rden;
    logic [WIDTH-1:0] fifo_data;
    logic             rdempty;
    logic [PTR:0]     rdusedw;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (
        output rden,
        input  fifo_data,
        input  rdempty,
        input  rdusedw,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rden,
        output fifo_data,
        output rdempty,
        output rdusedw,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer emitting bursts on a valid/ready stream
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int PTR       = 4,
    parameter int BURST_MIN = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    fifo_stream_reader_if.master bus,
    input  logic                 flush,
    output logic                 burst_active,
    output logic [7:0]           burst_cnt
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    localparam logic [PTR:0] ONE_USED = (PTR+1)'(1);
    localparam logic [PTR:0] MIN_USED = (PTR+1)'(BURST_MIN);
    localparam logic [8:0]   MAX_CNT  = 9'(MAX_BURST);

    state_t           state;
    logic [WIDTH-1:0] buf_data [2];
    logic [1:0]       buf_last;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;
    logic             inflight;
    logic             inflight_last;

    logic       pop;
    logic       push;
    logic       rden;
    logic       issue_last;
    logic       land_last;
    logic       start;
    logic [2:0] credit;

    assign pop    = bus.out_valid && bus.out_ready;
    assign push   = inflight;
    // Slots still free after this cycle's pop; keeps buffered + in-flight words at most 2.
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rden   = (state == BURST) && !bus.rdempty && (bus.rdusedw != '0) && (credit < 3'd2);

    assign issue_last = (bus.rdusedw == ONE_USED) || (({1'b0, burst_cnt} + 9'd1) == MAX_CNT);
    // A word landing as the FIFO runs dry mid-burst closes that burst.
    assign land_last  = inflight_last || ((state == BURST) && bus.rdempty);
    assign start      = !bus.rdempty && ((bus.rdusedw >= MIN_USED) || flush);

    assign bus.rden      = rden;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = buf_data[rd_ptr];
    assign bus.out_last  = buf_last[rd_ptr];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state         <= IDLE;
            burst_active  <= 1'b0;
            burst_cnt     <= 8'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= 2'b00;
        end else begin
            inflight      <= rden;
            inflight_last <= rden && issue_last;

            if (push) begin
                buf_data[wr_ptr] <= bus.fifo_data;
                buf_last[wr_ptr] <= land_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (rden && (burst_cnt != 8'hFF)) begin
                burst_cnt <= burst_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= BURST;
                        burst_active <= 1'b1;
                        burst_cnt    <= 8'd0;
                    end
                end
                BURST: begin
                    if ((rden && issue_last) || bus.rdempty) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((occ == 2'd0) && !inflight) begin
                        state        <= IDLE;
                        burst_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    burst_active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for the MAC's clock-domain-crossing FIFO. Issues read requests (`rden`) into the FIFO read port, absorbs its one-cycle read latency in a 2-entry output buffer, and presents words downstream as a valid/ready stream grouped into bursts with a `out_last` marker. Sits in the FIFO read clock domain between the FIFO and the transmit datapath.

## Interface
- `WIDTH`, 8: data word width; matches the FIFO.
- `PTR`, 4: FIFO pointer width; `rdusedw` is `PTR+1` bits.
- `BURST_MIN`, 4: minimum FIFO fill level that starts a burst when `flush` is low.
- `MAX_BURST`, 16: maximum words per burst, 1..255.

Ports:
- `clk`, in, 1: single clock, connected to the FIFO `rdclk`.
- `reset_`, in, 1: asynchronous, active-low reset.
- `rden`, out, 1: FIFO read request.
- `fifo_data`, in, WIDTH: FIFO `dataout`, valid the cycle after an accepted `rden`.
- `rdempty`, in, 1: FIFO empty.
- `rdusedw`, in, PTR+1: FIFO fill count.
- `flush`, in, 1: start a burst whenever the FIFO is non-empty, regardless of `BURST_MIN`.
- `out_valid`, out, 1: output word valid.
- `out_data`, out, WIDTH: output word.
- `out_last`, out, 1: final word of the current burst; qualified by `out_valid`.
- `out_ready`, in, 1: downstream accept.
- `burst_active`, out, 1: high in BURST and DRAIN.
- `burst_cnt`, out, 8: words issued in the current or most recent burst.

## Operation
- FSM states:
  - IDLE (reset state).
  - BURST.
  - DRAIN.
- Transitions:
  - IDLE -> BURST when `!rdempty && (rdusedw >= BURST_MIN || flush)`. `burst_cnt` clears to 0 on this transition.
  - BURST -> DRAIN on the cycle a read is issued that is tagged last (see below).
  - BURST -> DRAIN also when `rdempty` is high in BURST. In this case the last word already accepted or buffered carries no `out_last`. The word in flight, if any, is tagged last when it lands; otherwise `out_last` is not emitted for that burst.
  - DRAIN -> IDLE when the output buffer is empty and no read is in flight.
- Read issue:
  - `rden = (state==BURST) && !rdempty && rdusedw != 0 && (occ + inflight - pop) < 2`.
  - `occ` is the output buffer occupancy, 0..2.
  - `inflight` is `rden` registered.
  - `pop = out_valid && out_ready`.
  - `rden` depends combinationally on `out_ready`; this is required to sustain one word per cycle.
- Last tagging: a read is tagged last when `rdusedw == 1` at issue, or when `burst_cnt + 1 == MAX_BURST` at issue. The tag travels with the in-flight word into the buffer.
- `burst_cnt` increments on every issued `rden` and saturates at 255.
- Output buffer:
  - 2-entry FIFO of {data, last}.
  - Head drives `out_data`/`out_last`; `out_valid = (occ != 0)`.
  - Push happens when `inflight` is high, capturing `fifo_data` and the tag.
  - Push and pop in the same cycle leave `occ` unchanged.
  - Overflow cannot occur, by the credit rule.
- `out_data`/`out_last` hold steady while `out_valid && !out_ready`.
- `flush` is level-sensitive and only affects the IDLE -> BURST decision.

## Timing
- Reset values: `rden` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `burst_active` 0, `burst_cnt` 0, state IDLE, `occ` 0, `inflight` 0.
- Latency:
  - Cycle 0: IDLE sees the start condition.
  - Cycle 1: state is BURST and `rden` can assert.
  - Cycle 2: `fifo_data` is valid and is pushed.
  - Cycle 3: `out_valid` is high.
  - This 3 cycles is the minimum from the start condition to first `out_valid`.
- Throughput: 1 word/cycle with `out_ready` held high and the FIFO non-empty.
- Backpressure: with `out_ready` low, at most 2 words are outstanding (buffered plus in flight), and `rden` stays low until a pop.
- Reset asserted mid-burst clears everything immediately. A word in flight is discarded. The FIFO's own reset covers its contents.
- `rdempty`/`rdusedw` are sampled in `clk`; the FIFO guarantees they are synchronous to `rdclk`.

## Test plan
- Write 6 words (0x11..0x16), `BURST_MIN=4`, `out_ready=1` -> burst starts; 6 words out in order on consecutive cycles; `out_last` on 0x16; `burst_cnt=6`; returns to IDLE.
- Write 2 words, `flush=0` -> no `rden`, stays IDLE. Raise `flush` -> 2 words out, `out_last` on the second.
- 20 words queued, `MAX_BURST=16` -> first burst emits 16 words with `out_last` on the 16th, then a second burst emits 4 words with `out_last` on the 4th.
- 8 words queued, `out_ready` toggled 1,0,0,1,... -> no word lost or duplicated; `occ + inflight` never exceeds 2; data stable while stalled.
- FIFO empties mid-burst while the writer stalls (`rdempty` rises after 3 words) -> state goes to DRAIN then IDLE; no read is issued while `rdempty` is high.
- Assert `reset_` low with 1 word in flight and 2 buffered -> all outputs return to reset values in the same cycle; after release the FSM is in IDLE.
